host_instr_issuer: RTL and testbench

- Host-side transmitter for the accelerator's 64-bit instruction interface.
- Queues instructions pushed by the host and drives them onto the accelerator instruction input, one per cycle, under `buffer_full` backpressure.
- Captures the 32-bit result returned on the accelerator output for every READ instruction it issues.
- Sits between the host/testbench and the accelerator top-level; used as the standard driver in integration benches.

---
 rtl/host_instr_issuer.sv | 60 ++++++
 tb/tb_host_instr_issuer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/host_instr_issuer.sv
// host_instr_issuer: queues host instructions and issues them one per cycle to the accelerator, capturing READ results
module host_instr_issuer #(
    parameter int         DEPTH       = 8,
    parameter logic [3:0] READ_OPCODE = 4'hF,
    parameter int         RD_LATENCY  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push_valid,
    input  logic [63:0] push_data,
    output logic        push_ready,
    output logic [63:0] accel_instr,
    input  logic        buffer_full,
    input  logic [31:0] accel_result,
    output logic        result_valid,
    output logic [31:0] result_data,
    output logic [15:0] issued_count,
    output logic [3:0]  reads_pending,
    output logic        idle
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [63:0]           mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic [RD_LATENCY-1:0] tag;
    logic                  do_push, do_pop, is_read, cap;
    assign push_ready = count != CW'(DEPTH);
    assign do_push    = push_valid && push_ready && |push_data;
    assign do_pop     = |count && !buffer_full;
    assign is_read    = do_pop && mem[rd_ptr][63:60] == READ_OPCODE;
    assign cap        = tag[RD_LATENCY-1];
    assign idle       = count == '0 && reads_pending == '0;
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            tag           <= '0;
            accel_instr   <= '0;
            issued_count  <= '0;
            reads_pending <= '0;
            result_valid  <= 1'b0;
            result_data   <= '0;
        end else begin
            wr_ptr        <= wr_ptr + AW'(do_push);
            rd_ptr        <= rd_ptr + AW'(do_pop);
            count         <= count + CW'(do_push) - CW'(do_pop);
            tag           <= (tag << 1) | RD_LATENCY'(is_read);
            accel_instr   <= do_pop ? mem[rd_ptr] : '0;
            issued_count  <= issued_count + 16'(do_pop);
            reads_pending <= reads_pending + 4'(is_read) - 4'(cap);
            result_valid  <= cap;
            if (cap) result_data <= accel_result;
        end
    end
endmodule

// File: tb/tb_host_instr_issuer.sv
// tb_host_instr_issuer: table vectors, hand sequences and an issue/result scoreboard for host_instr_issuer
module tb_host_instr_issuer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        push_valid;
    logic [63:0] push_data;
    logic        push_ready;
    logic [63:0] accel_instr;
    logic        buffer_full;
    logic [31:0] accel_result;
    logic        result_valid;
    logic [31:0] result_data;
    logic [15:0] issued_count;
    logic [3:0]  reads_pending;
    logic        idle;

    localparam logic [63:0] W1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] W2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] W3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] WC = 64'hCCCC_CCCC_CCCC_CCCC;

    typedef struct {
        logic        pv;
        logic [63:0] pd;
        logic        bf;
        logic        pr;
        logic [63:0] ai;
        logic [15:0] ic;
        logic        id;
    } vec_t;

    vec_t        vecs [7];
    logic [63:0] exp_q [$];
    logic [31:0] res_q [$];
    int          n_checks = 0;
    int          n_fail = 0;

    host_instr_issuer dut (
        .clk(clk), .reset_n(reset_n), .push_valid(push_valid), .push_data(push_data),
        .push_ready(push_ready), .accel_instr(accel_instr), .buffer_full(buffer_full),
        .accel_result(accel_result), .result_valid(result_valid), .result_data(result_data),
        .issued_count(issued_count), .reads_pending(reads_pending), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pv, input logic [63:0] pd, input logic bf);
        push_valid  = pv;
        push_data   = pd;
        buffer_full = bf;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (idle !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        check(name, 64'(idle), 64'h1);
        repeat (2) tick();
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (accel_instr !== 64'h0) begin
                if (exp_q.size() == 0) check("unexpected_issue", accel_instr, 64'h0);
                else check("issue_order", accel_instr, exp_q.pop_front());
            end
            if (result_valid === 1'b1) begin
                if (res_q.size() == 0) check("unexpected_result_valid", 64'(result_valid), 64'h0);
                else check("result_capture", 64'(result_data), 64'(res_q.pop_front()));
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b1, W1,    1'b0, 1'b1, 64'h0, 16'd0, 1'b0};
        vecs[1] = '{1'b1, W2,    1'b0, 1'b1, W1,    16'd1, 1'b0};
        vecs[2] = '{1'b1, W3,    1'b0, 1'b1, W2,    16'd2, 1'b0};
        vecs[3] = '{1'b0, 64'h0, 1'b0, 1'b1, W3,    16'd3, 1'b1};
        vecs[4] = '{1'b0, 64'h0, 1'b0, 1'b1, 64'h0, 16'd3, 1'b1};
        vecs[5] = '{1'b1, 64'h0, 1'b0, 1'b1, 64'h0, 16'd3, 1'b1};
        vecs[6] = '{1'b0, 64'h0, 1'b0, 1'b1, 64'h0, 16'd3, 1'b1};
        reset_n      = 1'b0;
        accel_result = 32'h0;
        drive(1'b0, 64'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        check("rst_accel_instr", accel_instr, 64'h0);
        check("rst_push_ready", 64'(push_ready), 64'h1);
        check("rst_idle", 64'(idle), 64'h1);
        check("rst_issued_count", 64'(issued_count), 64'h0);
        check("rst_reads_pending", 64'(reads_pending), 64'h0);
        check("rst_result_valid", 64'(result_valid), 64'h0);
        check("rst_result_data", 64'(result_data), 64'h0);

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].pv, vecs[i].pd, vecs[i].bf);
            if (vecs[i].pv && vecs[i].pd != 64'h0) exp_q.push_back(vecs[i].pd);
            check($sformatf("v%0d_push_ready", i), 64'(push_ready), 64'(vecs[i].pr));
            tick();
            check($sformatf("v%0d_accel_instr", i), accel_instr, vecs[i].ai);
            check($sformatf("v%0d_issued_count", i), 64'(issued_count), 64'(vecs[i].ic));
            check($sformatf("v%0d_idle", i), 64'(idle), 64'(vecs[i].id));
        end

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, {4'hB, 60'(i + 1)}, 1'b1);
            exp_q.push_back({4'hB, 60'(i + 1)});
            check("bp_fill_ready", 64'(push_ready), 64'h1);
            tick();
            check("bp_hold_nop", accel_instr, 64'h0);
        end
        check("bp_full_ready", 64'(push_ready), 64'h0);
        drive(1'b1, WC, 1'b1);
        tick();
        check("bp_full_nop", accel_instr, 64'h0);
        check("bp_full_ready2", 64'(push_ready), 64'h0);
        drive(1'b1, WC, 1'b0);
        check("bp_no_full_bypass", 64'(push_ready), 64'h0);
        tick();
        drive(1'b0, 64'h0, 1'b0);
        check("bp_pop1", accel_instr, {4'hB, 60'd1});
        check("bp_ready_after_pop", 64'(push_ready), 64'h1);
        tick();
        check("bp_pop2", accel_instr, {4'hB, 60'd2});
        drive(1'b0, 64'h0, 1'b1);
        tick();
        check("bp_stall_nop", accel_instr, 64'h0);
        check("bp_issued_5", 64'(issued_count), 64'd5);
        drive(1'b0, 64'h0, 1'b0);
        wait_idle("bp_drain_idle");
        check("bp_issued_11", 64'(issued_count), 64'd11);

        accel_result = 32'hDEADBEEF;
        drive(1'b1, 64'hF000_0000_0000_0001, 1'b0);
        exp_q.push_back(64'hF000_0000_0000_0001);
        res_q.push_back(32'hDEADBEEF);
        tick();
        drive(1'b0, 64'h0, 1'b0);
        tick();
        check("rd_issue", accel_instr, 64'hF000_0000_0000_0001);
        check("rd_pending_1", 64'(reads_pending), 64'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rd_pending_hold", 64'(reads_pending), 64'd1);
            check("rd_no_early_valid", 64'(result_valid), 64'h0);
        end
        tick();
        accel_result = 32'h0;
        check("rd_valid_pulse", 64'(result_valid), 64'h1);
        check("rd_data", 64'(result_data), 64'hDEADBEEF);
        check("rd_pending_0", 64'(reads_pending), 64'd0);
        check("rd_idle", 64'(idle), 64'h1);
        tick();
        check("rd_valid_single", 64'(result_valid), 64'h0);
        check("rd_data_hold", 64'(result_data), 64'hDEADBEEF);

        accel_result = 32'h1234_5678;
        drive(1'b1, 64'hF000_0000_0000_0002, 1'b0);
        exp_q.push_back(64'hF000_0000_0000_0002);
        tick();
        drive(1'b1, 64'hF000_0000_0000_0003, 1'b0);
        exp_q.push_back(64'hF000_0000_0000_0003);
        tick();
        drive(1'b0, 64'h0, 1'b0);
        tick();
        check("rr_pending_2", 64'(reads_pending), 64'd2);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rr_async_accel_instr", accel_instr, 64'h0);
        check("rr_async_pending", 64'(reads_pending), 64'h0);
        check("rr_async_result_valid", 64'(result_valid), 64'h0);
        check("rr_async_result_data", 64'(result_data), 64'h0);
        check("rr_async_issued", 64'(issued_count), 64'h0);
        check("rr_async_push_ready", 64'(push_ready), 64'h1);
        check("rr_async_idle", 64'(idle), 64'h1);
        exp_q.delete();
        res_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (8) tick();
        check("rr_pending_after", 64'(reads_pending), 64'h0);
        check("rr_idle_after", 64'(idle), 64'h1);
        check("rr_no_valid", 64'(result_valid), 64'h0);

        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, 64'(i + 1), 1'b0);
            exp_q.push_back(64'(i + 1));
            tick();
        end
        drive(1'b0, 64'h0, 1'b0);
        wait_idle("wrap_drain_idle");
        check("wrap_ffff", 64'(issued_count), 64'hFFFF);
        drive(1'b1, 64'h5A5A, 1'b0);
        exp_q.push_back(64'h5A5A);
        tick();
        drive(1'b0, 64'h0, 1'b0);
        wait_idle("wrap_final_idle");
        check("wrap_zero", 64'(issued_count), 64'h0);

        check("scoreboard_issue_empty", 64'(exp_q.size()), 64'h0);
        check("scoreboard_result_empty", 64'(res_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
